// File: rtl/approx_mul_pkg.sv
// Shared types and helpers for the time-multiplexed approximate multiplier.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB = 4;

  // Ceiling log2, never below 1 so derived vectors always have a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/approx_mul_seq_core4.sv
// Shared 4x4 nibble multiplier; approximate mode clears the low TRUNC bits.
module ap_core4 #(
  parameter int TRUNC = 2
) (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       apx,
  output logic [7:0] p
);

  localparam logic [7:0] KEEP = 8'hFF << TRUNC;

  logic [7:0] exact;

  assign exact = {4'b0, x} * {4'b0, y};
  assign p     = apx ? (exact & KEEP) : exact;

endmodule

// File: rtl/approx_mul_seq.sv
// W x W unsigned multiplier built from one shared 4x4 core, one nibble
// partial product per cycle, accumulated behind valid/ready handshakes.
module approx_mul_seq
  import approx_mul_pkg::*;
#(
  parameter int W     = 8,
  parameter int TRUNC = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [W-1:0]                a,
  input  logic [W-1:0]                b,
  input  logic [(W/4)*(W/4)-1:0]      apx_mask,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*W-1:0]              prod
);

  localparam int N   = W / NIB;
  localparam int NPP = N * N;
  localparam int CW  = clog2(NPP);
  localparam int IW  = clog2(N);

  state_t state, state_nx;

  logic [N-1:0][NIB-1:0] a_q, b_q;
  logic [NPP-1:0]        mask_q;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         ii, jj;
  logic [2*W-1:0]        acc, prod_q, pp_sh;
  logic [7:0]            pp;
  logic                  accept, last;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CW'(NPP - 1));
  assign prod   = prod_q;

  ap_core4 #(.TRUNC(TRUNC)) u_core (
    .x   (a_q[ii]),
    .y   (b_q[jj]),
    .apx (mask_q[cnt]),
    .p   (pp)
  );

  assign pp_sh = {{(2*W-8){1'b0}}, pp} << (NIB * (int'(ii) + int'(jj)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN:  if (last) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // i/j are tracked alongside k so no divider is needed when N is not a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mask_q <= '0;
      acc    <= '0;
      prod_q <= '0;
      cnt    <= '0;
      ii     <= '0;
      jj     <= '0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      mask_q <= apx_mask;
      acc    <= '0;
      cnt    <= '0;
      ii     <= '0;
      jj     <= '0;
    end else if (state == RUN) begin
      acc <= acc + pp_sh;
      if (last) begin
        prod_q <= acc + pp_sh;
        cnt    <= '0;
        ii     <= '0;
        jj     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        if (jj == IW'(N - 1)) begin
          jj <= '0;
          ii <= ii + 1'b1;
        end else begin
          jj <= jj + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_seq.sv
// Directed vectors on a W=8 instance plus randomized traffic on a W=16 instance.
module tb_approx_mul_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [3:0]  m8;
  logic [15:0] prod8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, m16;
  logic [31:0] prod16;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  approx_mul_seq #(.W(8), .TRUNC(2)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .apx_mask(m8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .prod(prod8)
  );

  approx_mul_seq #(.W(16), .TRUNC(3)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .apx_mask(m16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .prod(prod16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  m;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Exact product minus the bits truncation removes from each masked partial.
  function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] m);
    logic [31:0] r;
    logic [7:0]  p;
    r = 32'(x) * 32'(y);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        p = {4'b0, x[4*i +: 4]} * {4'b0, y[4*j +: 4]};
        if (m[i*4 + j]) r = r - (32'(p & 8'h07) << (4 * (i + j)));
      end
    return r;
  endfunction

  task automatic wait_out8(input string nm, output int lat);
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s latency", nm), 64'(lat), 64'd4);
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] tm,
                      input logic [15:0] texp, input string nm);
    int lat;
    @(negedge clk);
    a8 = ta; b8 = tb_; m8 = tm; in_valid8 = 1'b1; out_ready8 = 1'b1;
    chk($sformatf("%s in_ready idle", nm), 64'(in_ready8), 64'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = ~ta; b8 = ~tb_; m8 = ~tm;
    chk($sformatf("%s in_ready run", nm), 64'(in_ready8), 64'd0);
    wait_out8(nm, lat);
    chk($sformatf("%s prod", nm), 64'(prod8), 64'(texp));
    @(posedge clk); #1;
    chk($sformatf("%s after hs {ov,ir}", nm), 64'({out_valid8, in_ready8}), 64'b01);
  endtask

  // Holds out_ready low in DONE while a competing operand set is offered.
  task automatic hold8(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] tm,
                       input logic [15:0] texp, input int ncyc, input string nm);
    int lat;
    @(negedge clk);
    a8 = ta; b8 = tb_; m8 = tm; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    wait_out8(nm, lat);
    chk($sformatf("%s prod", nm), 64'(prod8), 64'(texp));
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      a8 = 8'h55; b8 = 8'h55; m8 = 4'h0; in_valid8 = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("%s hold%0d {ov,ir,prod}", nm, c), 64'({out_valid8, in_ready8, prod8}),
          64'({1'b1, 1'b0, texp}));
    end
    @(negedge clk);
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("%s after hs {ov,ir,prod}", nm), 64'({out_valid8, in_ready8, prod8}),
        64'({1'b0, 1'b1, texp}));
  endtask

  initial begin
    vec_t vt[8];
    logic [31:0] exp16;
    int lat, r;

    vt[0] = '{8'hFF, 8'hFF, 4'b0000, 16'hFE01, "ff_exact"};
    vt[1] = '{8'hFF, 8'hFF, 4'b1111, 16'hFCE0, "ff_apx"};
    vt[2] = '{8'h23, 8'h45, 4'b0000, 16'h096F, "2345_exact"};
    vt[3] = '{8'h23, 8'h45, 4'b0001, 16'h096C, "2345_k0"};
    vt[4] = '{8'h23, 8'h45, 4'b0010, 16'h096F, "2345_k1"};
    vt[5] = '{8'h23, 8'h45, 4'b0100, 16'h094F, "2345_k2"};
    vt[6] = '{8'h10, 8'h01, 4'b1111, 16'h0000, "10x01_apx"};
    vt[7] = '{8'hFF, 8'h01, 4'b0000, 16'h00FF, "ffx01_exact"};

    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; m16 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset u8 {ir,ov,prod}", 64'({in_ready8, out_valid8, prod8}), 64'({1'b1, 1'b0, 16'h0}));
    chk("reset u16 {ir,ov,prod}", 64'({in_ready16, out_valid16, prod16}),
        64'({1'b1, 1'b0, 32'h0}));
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 8; v++)
      run8(vt[v].a, vt[v].b, vt[v].m, vt[v].exp, vt[v].nm);

    hold8(8'h00, 8'hA7, 4'b1111, 16'h0000, 5, "zero_hold");
    hold8(8'hFF, 8'hFF, 4'b1111, 16'hFCE0, 3, "ff_hold");

    // Abort a product in its second RUN cycle.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; m8 = 4'b0000; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrun reset {ir,ov,prod}", 64'({in_ready8, out_valid8, prod8}),
        64'({1'b1, 1'b0, 16'h0}));
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("post reset no out_valid", 64'(out_valid8), 64'd0);
    end
    run8(8'h02, 8'h03, 4'b0000, 16'h0006, "post_reset");

    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); m16 = 16'($urandom);
      exp16 = model16(a16, b16, m16);
      in_valid16 = 1'b1; out_ready16 = 1'b0;
      chk($sformatf("rnd%0d in_ready", t), 64'(in_ready16), 64'd1);
      @(posedge clk); #1;
      in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); m16 = 16'($urandom);
      lat = 0;
      while (!out_valid16 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("rnd%0d latency", t), 64'(lat), 64'd16);
      r = $urandom_range(0, 3);
      repeat (r) @(posedge clk);
      @(negedge clk);
      chk($sformatf("rnd%0d prod", t), 64'(prod16), 64'(exp16));
      out_ready16 = 1'b1;
      @(posedge clk); #1;
      out_ready16 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
